// File: rtl/memory_access_stage.sv
// Memory stage: drives data-RAM req/ack transactions for loads/stores,
// stalls upstream while busy, and holds the memory/writeback register.
// Ports: clock/reset (async, active-low); memory_* latch inputs;
// ram_* request port (req/we/address/wdata out, rdata/ack in);
// memory_stall (comb); writeback_* registered outputs.
module memory_access_stage #(
  parameter int ADDR_WIDTH = 12,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           memory_instruction,
  input  logic [31:0]           memory_input_a,
  input  logic [31:0]           memory_input_b,
  input  logic [4:0]            memory_regfile_write_address,
  input  logic                  memory_refile_write_en,
  input  logic                  memory_ram_to_register_en,
  input  logic                  memory_write_to_ram_en,
  input  logic                  memory_overflow,
  output logic                  ram_req,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata,
  input  logic                  ram_ack,
  output logic                  memory_stall,
  output logic [31:0]           writeback_instruction,
  output logic [31:0]           writeback_data,
  output logic [4:0]            writeback_regfile_write_address,
  output logic                  writeback_regfile_write_en,
  output logic                  writeback_overflow,
  output logic                  writeback_bus_error
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] count;
  logic          error;
  logic [31:0]   rdata_q;
  logic          access;
  logic          timeout_hit;

  // Overflowing loads/stores never touch the RAM.
  assign access = (memory_ram_to_register_en
                 | memory_write_to_ram_en)
                & ~memory_overflow;

  assign timeout_hit = (count == CW'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (access) state_nxt = ACCESS;
      ACCESS:  if (ram_ack || timeout_hit)
                 state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    memory_stall = 1'b0;
    unique case (state)
      IDLE:    memory_stall = access;
      ACCESS:  memory_stall = 1'b1;
      default: memory_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ram_req                         <= 1'b0;
      ram_we                          <= 1'b0;
      ram_address                     <= '0;
      ram_wdata                       <= '0;
      count                           <= '0;
      error                           <= 1'b0;
      rdata_q                         <= '0;
      writeback_instruction           <= '0;
      writeback_data                  <= '0;
      writeback_regfile_write_address <= '0;
      writeback_regfile_write_en      <= 1'b0;
      writeback_overflow              <= 1'b0;
      writeback_bus_error             <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (access) begin
            ram_req     <= 1'b1;
            ram_we      <= memory_write_to_ram_en;
            ram_address <=
              memory_input_a[ADDR_WIDTH+1:2];
            ram_wdata   <= memory_input_b;
            count       <= '0;
            writeback_instruction           <= '0;
            writeback_data                  <= '0;
            writeback_regfile_write_address <= '0;
            writeback_regfile_write_en      <= 1'b0;
            writeback_overflow              <= 1'b0;
            writeback_bus_error             <= 1'b0;
          end else begin
            writeback_instruction <= memory_instruction;
            writeback_data        <= memory_input_a;
            writeback_regfile_write_address <=
              memory_regfile_write_address;
            writeback_regfile_write_en <=
              memory_refile_write_en & ~memory_overflow;
            writeback_overflow  <= memory_overflow;
            writeback_bus_error <= 1'b0;
          end
        end
        ACCESS: begin
          writeback_instruction           <= '0;
          writeback_data                  <= '0;
          writeback_regfile_write_address <= '0;
          writeback_regfile_write_en      <= 1'b0;
          writeback_overflow              <= 1'b0;
          writeback_bus_error             <= 1'b0;
          if (ram_ack) begin
            ram_req <= 1'b0;
            ram_we  <= 1'b0;
            rdata_q <= ram_rdata;
          end else if (timeout_hit) begin
            ram_req <= 1'b0;
            ram_we  <= 1'b0;
            error   <= 1'b1;
          end else begin
            count <= count + CW'(1);
          end
        end
        DONE: begin
          writeback_instruction <= memory_instruction;
          writeback_data <= memory_ram_to_register_en
                          ? rdata_q : memory_input_a;
          writeback_regfile_write_address <=
            memory_regfile_write_address;
          writeback_regfile_write_en <=
            memory_refile_write_en & ~error;
          writeback_overflow  <= memory_overflow;
          writeback_bus_error <= error;
          error               <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: directed cases then random
// transactions checked against a transaction-level model.
module tb_memory_access_stage;

  localparam int AW = 12;
  localparam int TO = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   memory_instruction = '0;
  logic [31:0]   memory_input_a = '0;
  logic [31:0]   memory_input_b = '0;
  logic [4:0]    memory_regfile_write_address = '0;
  logic          memory_refile_write_en = 1'b0;
  logic          memory_ram_to_register_en = 1'b0;
  logic          memory_write_to_ram_en = 1'b0;
  logic          memory_overflow = 1'b0;
  logic          ram_req;
  logic          ram_we;
  logic [AW-1:0] ram_address;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata = '0;
  logic          ram_ack = 1'b0;
  logic          memory_stall;
  logic [31:0]   writeback_instruction;
  logic [31:0]   writeback_data;
  logic [4:0]    writeback_regfile_write_address;
  logic          writeback_regfile_write_en;
  logic          writeback_overflow;
  logic          writeback_bus_error;

  int tests = 0;
  int fails = 0;

  memory_access_stage #(
    .ADDR_WIDTH(AW),
    .TIMEOUT(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .memory_instruction(memory_instruction),
    .memory_input_a(memory_input_a),
    .memory_input_b(memory_input_b),
    .memory_regfile_write_address(memory_regfile_write_address),
    .memory_refile_write_en(memory_refile_write_en),
    .memory_ram_to_register_en(memory_ram_to_register_en),
    .memory_write_to_ram_en(memory_write_to_ram_en),
    .memory_overflow(memory_overflow),
    .ram_req(ram_req),
    .ram_we(ram_we),
    .ram_address(ram_address),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .ram_ack(ram_ack),
    .memory_stall(memory_stall),
    .writeback_instruction(writeback_instruction),
    .writeback_data(writeback_data),
    .writeback_regfile_write_address(writeback_regfile_write_address),
    .writeback_regfile_write_en(writeback_regfile_write_en),
    .writeback_overflow(writeback_overflow),
    .writeback_bus_error(writeback_bus_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic check_wb_zero(input string tag);
    check({tag, ".wb_instr"}, writeback_instruction, 0);
    check({tag, ".wb_data"}, writeback_data, 0);
    check({tag, ".wb_addr"}, 32'(writeback_regfile_write_address), 0);
    check({tag, ".wb_en"}, 32'(writeback_regfile_write_en), 0);
    check({tag, ".wb_ovf"}, 32'(writeback_overflow), 0);
    check({tag, ".wb_berr"}, 32'(writeback_bus_error), 0);
  endtask

  // One instruction through the stage. Called at posedge+1.
  // ack_n: ack is presented for sampling at edge E1+ack_n;
  // any ack_n above TO means the RAM never answers.
  task automatic run_op(input string tag,
                        input logic [31:0] instr,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [4:0]  rd,
                        input logic        en,
                        input logic        ld,
                        input logic        st,
                        input logic        ovf,
                        input int          ack_n,
                        input logic [31:0] rdata);
    logic acc;
    logic err;
    int   stall_cyc;
    int   req_cyc;
    int   k;
    logic [AW-1:0] exp_addr;
    logic [31:0]   exp_data;
    acc = (ld | st) & ~ovf;
    err = acc && (ack_n > TO);
    exp_addr = AW'(a / 4);
    memory_instruction           = instr;
    memory_input_a               = a;
    memory_input_b               = b;
    memory_regfile_write_address = rd;
    memory_refile_write_en       = en;
    memory_ram_to_register_en    = ld;
    memory_write_to_ram_en       = st;
    memory_overflow              = ovf;
    #1;
    if (!acc) begin
      check({tag, ".stall"}, 32'(memory_stall), 0);
      @(posedge clock); #1;
      check({tag, ".req"}, 32'(ram_req), 0);
      check({tag, ".wb_data"}, writeback_data, a);
      check({tag, ".wb_instr"}, writeback_instruction, instr);
      check({tag, ".wb_addr"}, 32'(writeback_regfile_write_address),
            32'(rd));
      check({tag, ".wb_en"}, 32'(writeback_regfile_write_en),
            32'(en & ~ovf));
      check({tag, ".wb_ovf"}, 32'(writeback_overflow), 32'(ovf));
      check({tag, ".wb_berr"}, 32'(writeback_bus_error), 0);
      return;
    end
    stall_cyc = 0;
    req_cyc = 0;
    k = 0;
    while (memory_stall && k < 300) begin
      stall_cyc++;
      if (ram_req) begin
        req_cyc++;
        check({tag, ".ram_addr"}, 32'(ram_address), 32'(exp_addr));
        check({tag, ".ram_we"}, 32'(ram_we), 32'(st));
        if (st) check({tag, ".ram_wdata"}, ram_wdata, b);
        check({tag, ".bubble_en"},
              32'(writeback_regfile_write_en), 0);
      end
      ram_ack   = ram_req && (req_cyc == ack_n);
      ram_rdata = ram_ack ? rdata : 32'($urandom);
      @(posedge clock); #1;
      ram_ack = 1'b0;
      k++;
    end
    check({tag, ".no_hang"}, 32'(k < 300), 1);
    check({tag, ".stall_cycles"}, 32'(stall_cyc),
          32'(err ? TO + 1 : ack_n + 1));
    check({tag, ".req_cycles"}, 32'(req_cyc),
          32'(err ? TO : ack_n));
    check({tag, ".req_done"}, 32'(ram_req), 0);
    // An ack now must be ignored.
    ram_ack   = 1'($urandom);
    ram_rdata = 32'($urandom);
    @(posedge clock); #1;
    ram_ack = 1'b0;
    exp_data = ld ? rdata : a;
    if (!err) check({tag, ".wb_data"}, writeback_data, exp_data);
    check({tag, ".wb_instr"}, writeback_instruction, instr);
    check({tag, ".wb_addr"}, 32'(writeback_regfile_write_address),
          32'(rd));
    check({tag, ".wb_en"}, 32'(writeback_regfile_write_en),
          32'(en & ~err));
    check({tag, ".wb_berr"}, 32'(writeback_bus_error), 32'(err));
    check({tag, ".wb_ovf"}, 32'(writeback_overflow), 0);
    check({tag, ".req_idle"}, 32'(ram_req), 0);
  endtask

  initial begin
    logic [31:0] r;
    int kind;
    #12;
    check("reset.req", 32'(ram_req), 0);
    check("reset.we", 32'(ram_we), 0);
    check("reset.addr", 32'(ram_address), 0);
    check("reset.stall", 32'(memory_stall), 0);
    check_wb_zero("reset");
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;

    run_op("alu", 32'h0000_0013, 32'h0000_1234, 32'h0, 5'd5,
           1'b1, 1'b0, 1'b0, 1'b0, 0, 32'h0);
    run_op("load", 32'h0000_2003, 32'h0000_0010, 32'h0, 5'd7,
           1'b1, 1'b1, 1'b0, 1'b0, 2, 32'hDEAD_BEEF);
    run_op("store", 32'h0000_2023, 32'h0000_0020, 32'hCAFE_F00D,
           5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 32'h0);
    run_op("ovf_store", 32'h0000_2023, 32'h0000_0044, 32'h1111_2222,
           5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 0, 32'h0);
    run_op("ovf_load", 32'h0000_2003, 32'h0000_0048, 32'h0,
           5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 0, 32'h0);
    run_op("timeout", 32'h0000_2003, 32'h0000_0030, 32'h0, 5'd6,
           1'b1, 1'b1, 1'b0, 1'b0, 99, 32'h0);
    run_op("alu_after_to", 32'h0000_0033, 32'h0000_5678, 32'h0,
           5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 0, 32'h0);
    run_op("ack_at_limit", 32'h0000_2003, 32'h0000_0FFC, 32'h0,
           5'd2, 1'b1, 1'b1, 1'b0, 1'b0, TO, 32'h1234_5678);

    // Reset mid-access; upstream latch resets alongside.
    memory_instruction        = 32'h0000_2003;
    memory_input_a            = 32'h0000_0050;
    memory_regfile_write_address = 5'd4;
    memory_refile_write_en    = 1'b1;
    memory_ram_to_register_en = 1'b1;
    memory_write_to_ram_en    = 1'b0;
    memory_overflow           = 1'b0;
    @(posedge clock); #1;
    check("rst_mid.req_up", 32'(ram_req), 1);
    @(posedge clock); #3;
    reset = 1'b0;
    memory_instruction        = '0;
    memory_input_a            = '0;
    memory_regfile_write_address = '0;
    memory_refile_write_en    = 1'b0;
    memory_ram_to_register_en = 1'b0;
    #1;
    check("rst_mid.req", 32'(ram_req), 0);
    check("rst_mid.stall", 32'(memory_stall), 0);
    check_wb_zero("rst_mid");
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    check_wb_zero("rst_rel");
    run_op("load_after_rst", 32'h0000_2083, 32'h0000_0100, 32'h0,
           5'd11, 1'b1, 1'b1, 1'b0, 1'b0, 3, 32'hA5A5_5A5A);

    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 3));
      r = $urandom;
      run_op("rand", $urandom, $urandom, $urandom, 5'(r),
             r[5], kind == 1, kind == 2,
             (kind != 0) && (r[9:7] == 3'd0),
             int'($urandom_range(1, TO + 2)), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/memory_access_stage.md
# memory_access_stage

Memory-stage consumer of the execute/memory pipeline latch outputs: turns the latched load/store controls into a request/acknowledge transaction on the data-RAM port, and stalls the upstream pipeline while the RAM is busy. It also holds the memory/writeback pipeline register, which carries the result, destination register and write enable to the writeback stage. Sits between the execute/memory latch and the regfile write port.

## Interface
- ADDR_WIDTH, 12, RAM word-address width.
- TIMEOUT, 255, maximum number of ACCESS cycles waited for ram_ack before abort; must be ≥1.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low (0 = reset); clears all state immediately.
- memory_instruction  in  32  instruction from execute/memory latch.
- memory_input_a  in  32  ALU result / byte address.
- memory_input_b  in  32  store data.
- memory_regfile_write_address  in  5  destination register.
- memory_refile_write_en  in  1  regfile write enable.
- memory_ram_to_register_en  in  1  load.
- memory_write_to_ram_en  in  1  store.
- memory_overflow  in  1  ALU overflow.
- ram_req  out  1  registered RAM request.
- ram_we  out  1  registered; 1 = write.
- ram_address  out  ADDR_WIDTH  registered word address = memory_input_a[ADDR_WIDTH+1:2].
- ram_wdata  out  32  registered store data.
- ram_rdata  in  32  read data, valid with ram_ack.
- ram_ack  in  1  transfer complete.
- memory_stall  out  1  combinational; 1 = upstream stages hold.
- writeback_instruction  out  32  registered.
- writeback_data  out  32  registered result.
- writeback_regfile_write_address  out  5  registered.
- writeback_regfile_write_en  out  1  registered.
- writeback_overflow  out  1  registered.
- writeback_bus_error  out  1  registered; 1 = access timed out.

## Operation
- access = (memory_ram_to_register_en | memory_write_to_ram_en) & ~memory_overflow.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, access=0: memory_stall=0. At the edge, the writeback register captures instruction, data=memory_input_a, address, en=memory_refile_write_en & ~memory_overflow, overflow=memory_overflow, bus_error=0.
- IDLE, access=1: memory_stall=1. At the edge: ram_req←1, ram_we←store, ram_address and ram_wdata registered, timeout counter←0, writeback register loads a bubble (instruction 0, en 0, data 0, bus_error 0), go to ACCESS.
- ACCESS: memory_stall=1 and ram_req held. At an edge with ram_ack=1: ram_req←0, ram_we←0, load data←ram_rdata, go to DONE. Otherwise the counter increments. If the counter reaches TIMEOUT−1 with no ack: ram_req←0, error flag←1, go to DONE. The writeback register loads a bubble every ACCESS cycle.
- DONE: memory_stall=0. The latch inputs still hold the same instruction. At the edge the writeback register captures: data = load ? captured rdata : memory_input_a; en = memory_refile_write_en & ~error; bus_error = error. Error flag clears; go to IDLE.
- ram_ack is ignored in IDLE and DONE.
- Store with overflow never reaches the RAM. Load with overflow produces no regfile write.
- Timeout counter width is clog2(TIMEOUT+1). Address uses word addressing; bits [1:0] are discarded.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0, error flag 0. With reset inputs from upstream, memory_stall=0.
- Reset during ACCESS: ram_req drops immediately (asynchronous), no writeback issued, FSM returns to IDLE.
- Non-access latency: 1 edge from input to writeback register, no stall.
- Access latency: ram_req rises at edge E1. If ram_ack is first sampled high at edge E1+n (n≥1), memory_stall is high for n+1 cycles. The writeback register is valid one edge after stall falls.
- Timeout: ram_req is high for exactly TIMEOUT edges, then DONE.
- ram_req never drops without an ack or a timeout. The address, write data and write enable on the RAM port are stable while ram_req=1.

## Test plan
- ALU op: input_a=0x00001234, address=5, en=1, no load/store. Required: next edge writeback_data=0x00001234, address 5, en 1; ram_req never rises; stall 0.
- Load: input_a=0x00000010, ack sampled at edge E1+2 with rdata=0xDEADBEEF. Required: ram_address=4, ram_we=0, stall high 3 cycles, writeback_data=0xDEADBEEF, en 1.
- Store: input_a=0x00000020, input_b=0xCAFEF00D, ack at E1+1. Required: ram_address=8, ram_wdata=0xCAFEF00D, ram_we=1, stall high 2 cycles, writeback en 0.
- Overflow store: overflow=1, store=1. Required: no ram_req, stall 0, writeback_overflow=1, en 0.
- Timeout: TIMEOUT=4, load with no ack. Required: ram_req high 4 edges then low, writeback_bus_error=1, en 0; subsequent ALU op completes normally.
- Reset asserted mid-ACCESS. Required: ram_req, stall and all writeback outputs 0 immediately; after release, a new load completes normally.
